rank_stack_reader: RTL
======================

RANK_STACK_READER -- requirements
Module: rank_stack_reader

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the bit width of one stack entry.
REQ-002 The block SHALL have parameter N, default 5, meaning the number of entries in the sorted stack.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide; reset is synchronous and active-low.
REQ-005 Port snap_req SHALL be an input, 1 bit wide: request to capture the stack and stream it out.
REQ-006 Port sd_flat SHALL be an input, N*DW bits wide: the sorted stack from the filter; entry k (k=0 smallest) is at bits [k*DW +: DW].
REQ-007 Port desc SHALL be an input, 1 bit wide: 0 = emit ascending, 1 = emit descending; it is sampled with snap_req.
REQ-008 Port m_ready SHALL be an input, 1 bit wide: the downstream can accept a beat.
REQ-009 Port m_valid SHALL be an output, 1 bit wide, registered: m_data is valid.
REQ-010 Port m_data SHALL be an output, DW bits wide, registered: the current stack entry.
REQ-011 Port m_idx SHALL be an output, 3 bits wide, registered: the rank of m_data in the ascending stack, 0..N-1.
REQ-012 Port m_last SHALL be an output, 1 bit wide, registered: marks the final beat of the snapshot.
REQ-013 Port busy SHALL be an output, 1 bit wide, registered: high whenever the state is SEND.
REQ-014 Port drop_cnt SHALL be an output, 8 bits wide, registered: the count of dropped requests, saturating at 255.
REQ-015 Port seq_err SHALL be an output, 1 bit wide, registered and sticky: a captured snapshot was not non-decreasing.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SEND, and SHALL reset to IDLE.
REQ-017 In IDLE with snap_req=1 at a rising edge, the block SHALL capture sd_flat and desc into a local snapshot register.
REQ-018 On that same capture, the block SHALL enter SEND with m_valid=1 on the next cycle, so latency from snap_req to the first beat is 1 cycle.
REQ-019 The first beat SHALL carry entry 0 if desc=0 and entry N-1 if desc=1.
REQ-020 A beat SHALL transfer only at a rising edge where m_valid=1 and m_ready=1.
REQ-021 On each transfer, the index SHALL step by +1 when desc=0 and by -1 when desc=1.
REQ-022 Exactly N beats SHALL be emitted per snapshot.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_idx and m_last SHALL hold stable.
REQ-024 m_valid SHALL NOT depend combinationally on m_ready.
REQ-025 m_last SHALL be 1 only on the Nth beat.
REQ-026 When the Nth beat transfers and snap_req=0, the block SHALL return to IDLE, with m_valid=0 on the next cycle.
REQ-027 When the Nth beat transfers in the same cycle as snap_req=1, the block SHALL accept a new snapshot, stay in SEND, and present its first beat on the next cycle with no bubble.
REQ-028 snap_req=1 in SEND on any cycle other than the case in REQ-027 SHALL be ignored, and drop_cnt SHALL increment by 1, saturating at 255.
REQ-029 The live sd_flat SHALL NOT affect output beats after capture; changes to it during SEND are ignored.
REQ-030 At capture, if any entry k+1 is less than entry k (unsigned), seq_err SHALL set and remain set until reset.
REQ-031 A seq_err snapshot SHALL still be streamed normally.
REQ-032 In IDLE, m_data, m_idx and m_last SHALL hold 0.

Reset
REQ-033 When rst_n=0 at a rising edge, the block SHALL go to IDLE with m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, drop_cnt=0, seq_err=0, and a zeroed snapshot.
REQ-034 Reset asserted mid-snapshot SHALL abort the stream immediately, with m_valid=0 on the cycle after the reset edge and no further beats.
REQ-035 Any snap_req coinciding with rst_n=0 SHALL be ignored.

Structure
REQ-036 Package rank_pkg SHALL hold the DW and N defaults, the state enum (IDLE, SEND) and the drop_cnt saturation constant 255.
REQ-037 The monotonicity check SHALL be a combinational sub-module named rank_seq_check, with input N*DW bits and a 1-bit output.
REQ-038 rank_stack_reader SHALL instantiate rank_seq_check once.

Verification
REQ-039 Ascending read: stack {3,7,7,9,200}, desc=0, m_ready=1 throughout, one snap_req pulse -> beats 3,7,7,9,200 on 5 consecutive cycles starting 1 cycle after the pulse; m_idx 0..4; m_last only on 200; m_valid=0 afterwards.
REQ-040 Descending with backpressure: the same stack, desc=1, m_ready toggling 1,0,0,1,... -> beats 200,9,7,7,3 each held stable while m_ready=0; m_idx 4..0.
REQ-041 Drop and saturation: 300 snap_req pulses while stalled in SEND (m_ready=0) -> drop_cnt=255; the stream is unaffected.
REQ-042 Back-to-back: snap_req=1 on the cycle the beat with m_last=1 transfers, with the stack now {1,2,3,4,5} -> the next cycle shows beat 1 with m_valid continuously high, and drop_cnt is unchanged.
REQ-043 Sequence error: stack {5,4,6,7,8} captured -> seq_err=1, the beats emitted are 5,4,6,7,8, and seq_err stays 1 until rst_n=0.
REQ-044 Reset mid-stream: rst_n=0 after the 2nd beat -> all outputs are 0 on the next cycle and no further beats follow; a new snap_req after reset starts again from the first entry.

Source files
------------

// File: rtl/rank_pkg.sv
// Shared defaults and types for the rank stack reader.
package rank_pkg;

    localparam int DW_DEF = 8;
    localparam int N_DEF  = 5;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rank_seq_check.sv
// Combinational check that a flattened stack is non-decreasing (unsigned).
module rank_seq_check #(
    parameter int DW = 8,
    parameter int N  = 5
) (
    input  logic [N*DW-1:0] stack,
    output logic            err
);

    always_comb begin
        err = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (stack[(k+1)*DW +: DW] < stack[k*DW +: DW])
                err = 1'b1;
        end
    end

endmodule

// File: rtl/rank_stack_reader.sv
// Captures a sorted stack on request and streams it out one entry per beat,
// ascending or descending, with valid/ready handshaking.
module rank_stack_reader
    import rank_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            snap_req,
    input  logic [N*DW-1:0] sd_flat,
    input  logic            desc,
    input  logic            m_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic [2:0]      m_idx,
    output logic            m_last,
    output logic            busy,
    output logic [7:0]      drop_cnt,
    output logic            seq_err
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    state_t          state;
    logic [N*DW-1:0] snap;
    logic            snap_desc;
    logic [2:0]      cnt;
    logic            seq_bad;

    logic            xfer;
    logic            end_xfer;
    logic            capture;
    logic [2:0]      first_idx;
    logic [2:0]      next_idx;

    rank_seq_check #(.DW(DW), .N(N)) u_seq_check (
        .stack (sd_flat),
        .err   (seq_bad)
    );

    function automatic logic [DW-1:0] entry(input logic [N*DW-1:0] s, input logic [2:0] k);
        return s[k*DW +: DW];
    endfunction

    assign xfer      = m_valid & m_ready;
    assign end_xfer  = xfer & m_last;
    // A new snapshot is only taken when idle or exactly as the final beat leaves.
    assign capture   = snap_req & ((state == IDLE) | end_xfer);
    assign first_idx = desc ? LAST_IDX : 3'd0;
    assign next_idx  = snap_desc ? (m_idx - 3'd1) : (m_idx + 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            snap_desc <= 1'b0;
            cnt       <= 3'd0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_idx     <= 3'd0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            drop_cnt  <= 8'd0;
            seq_err   <= 1'b0;
        end else begin
            if (snap_req && !capture && drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + 8'd1;

            if (capture) begin
                state     <= SEND;
                snap      <= sd_flat;
                snap_desc <= desc;
                cnt       <= 3'd0;
                m_valid   <= 1'b1;
                busy      <= 1'b1;
                m_idx     <= first_idx;
                m_data    <= entry(sd_flat, first_idx);
                m_last    <= (N == 1);
                if (seq_bad)
                    seq_err <= 1'b1;
            end else if (end_xfer) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                busy    <= 1'b0;
                m_data  <= '0;
                m_idx   <= 3'd0;
                m_last  <= 1'b0;
            end else if (xfer) begin
                cnt    <= cnt + 3'd1;
                m_idx  <= next_idx;
                m_data <= entry(snap, next_idx);
                m_last <= ((cnt + 3'd1) == LAST_IDX);
            end
        end
    end

endmodule
